int_ctrl: RTL and testbench
===========================

# int_ctrl

Vectored interrupt controller that sequences the next-PC unit's interrupt-redirect path: it latches edge-triggered requests, picks the highest-priority unmasked one, and drives `int_sig_o`/`int_addr_o` into the next-PC mux. It also saves the return PC (EPC) and redirects back to it on `mret`. It sits beside the next-PC logic in the fetch stage and is configured by the core through a single register-write port.

## Interface
- `NUM_IRQ`, 4: number of interrupt sources, 1..16.
- `VEC_BASE`, 32'h0000_1000: address of vector 0.
- `VEC_SHIFT`, 4: vector stride is `1 << VEC_SHIFT` bytes.
- `clk` in 1: core clock, rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `irq_i` in NUM_IRQ: raw request lines; a rising edge requests service.
- `cfg_we` in 1: write strobe for the config register.
- `cfg_wdata` in NUM_IRQ+1: `{gie, mask[NUM_IRQ-1:0]}`.
- `npc_i` in 32: the core's next PC before any interrupt override; captured as EPC.
- `stall_i` in 1: pipeline stall; the redirect must not commit while it is high.
- `mret_i` in 1: a decoded `mret` is executing this cycle.
- `int_sig_o` out 1: override request to the next-PC mux.
- `int_addr_o` out 32: redirect target (a vector address or EPC).
- `irq_ack_o` out NUM_IRQ: one-hot, one-cycle pulse when a source is taken.
- `epc_o` out 32: saved return PC.
- `cause_o` out 4: id of the last taken source.
- `in_isr_o` out 1: high while state is ISR.

## Operation
- **Edge detect.** `irq_q <= irq_i`. `edge = irq_i & ~irq_q`. On each edge, `pend[i]` is set.
- **Pending bits.** A second edge while `pend[i]` is already set is absorbed (one pending bit per source). If an edge and an ack hit the same bit in the same cycle, the set wins.
- **Eligibility.** `elig = pend & mask`, gated by `gie`. Priority is lowest index highest.
- **FSM states.** IDLE, ARB, ENTER, ISR.
- **IDLE → ARB** when `gie && |elig`.
- **ARB** (one cycle):
  - registers the winning id into `cause`;
  - registers `int_addr_q = VEC_BASE + (id << VEC_SHIFT)`;
  - goes to ENTER.
  - If `elig` became 0 in ARB (because of a `cfg` write), it returns to IDLE with no ack.
- **ENTER:**
  - `int_sig_o = 1` and `int_addr_o = int_addr_q`.
  - While `stall_i` is high, the FSM stays in ENTER with outputs held.
  - On the first cycle with `stall_i` low, the redirect commits:
    - `epc <= npc_i`;
    - `pend[cause]` cleared;
    - `irq_ack_o[cause]` pulses;
    - `pgie <= gie`, then `gie <= 0`;
    - go to ISR.
  - A `cfg` write in ENTER does not abort the entry.
- **ISR:**
  - when `mret_i` is high, `int_sig_o = 1` and `int_addr_o = epc` in that same cycle (combinational);
  - at the clock edge: `gie <= pgie`, go to IDLE.
  - If `cfg_we` and `mret_i` occur in the same cycle, the restore of `pgie` wins for `gie`; the mask is still written.
- **Outside ISR:** `mret_i` is ignored.
- **Config writes:** `cfg_we` writes `gie` and `mask` in any state, except for the ENTER-commit edge, where `gie` is forced to 0.
- **Outputs:** `int_sig_o` is 0 in IDLE/ARB, and in ISR without `mret_i`. `int_addr_o` is 0 whenever `int_sig_o` is 0.
- **Arithmetic:** vector arithmetic is 32-bit and wraps mod 2^32.

## Timing
- **Reset** (asynchronous, immediate):
  - state IDLE;
  - `pend`, `mask`, `gie`, `pgie`, `irq_q`, `epc`, `cause` = 0;
  - all outputs 0.
- **Latency.** Edge seen at `irq_i` in cycle k:
  - `pend` set at cycle k+1;
  - ARB at k+2;
  - `int_sig_o` high at k+3 (when not stalled).
- **Ack timing.** `irq_ack_o` pulses in the commit cycle, coincident with the last `int_sig_o` cycle of the entry.
- **Back-to-back.** After `mret`, a still-pending source gives IDLE, then ARB, then ENTER: at least 3 cycles after the `mret` cycle.
- **Reset mid-ENTER/ISR.** Everything returns to the reset state. No ack is issued and no EPC is retained.

## Configuration
- `INTC_SYNC_EN` defined: `irq_i` passes through a 2-flop synchronizer before edge detect. All request latencies grow by 2 cycles, so `int_sig_o` first goes high at k+5.
- `INTC_SYNC_EN` undefined: `irq_i` is assumed synchronous to `clk`; no synchronizer.

## Structure
- **Package `intc_pkg`:**
  - FSM state encoding (IDLE=2'd0, ARB=2'd1, ENTER=2'd2, ISR=2'd3);
  - the cause width;
  - default `VEC_BASE`/`VEC_SHIFT`.
- **`NPC_INTADDR`** stays in `ctrl_encode_def.v`.
- **Sub-module `intc_prio_enc`:** combinational lowest-index-first encoder over NUM_IRQ bits, outputting `valid` and `id`.

## Test plan
- **Single request.** `mask=4'b0100`, `gie=1`, rising edge on `irq_i[2]` at cycle 10, `npc_i=32'h200` → `int_sig_o` high at cycle 13 with `int_addr_o=32'h1020`; `irq_ack_o=4'b0100`; then `epc_o=32'h200`, `cause_o=2`, `in_isr_o=1`.
- **Priority and re-entry.** Edges on `irq_i[3]` and `irq_i[1]` in the same cycle, all sources unmasked → vector `32'h1010` taken first. `mret` → `int_addr_o=epc`. Source 3 is then taken at `32'h1030`, at least 3 cycles after `mret`.
- **Stall hold.** `stall_i=1` for 4 cycles in ENTER → `int_sig_o` and `int_addr_o` held, no ack. Ack and EPC capture occur on the first unstalled cycle.
- **Masking.** Edge on a masked `irq_i[0]` → no `int_sig_o`. A later `cfg_we` with `mask=4'b0001`, `gie=1` → entry to `32'h1000`.
- **`mret` rules.** `mret_i` in IDLE → no `int_sig_o`. `gie` is 0 in ISR and restored to 1 after `mret`.
- **Reset mid-ISR.** `rstn` low during ISR → all outputs 0 and `pend` cleared. A new edge after reset is serviced normally.

Source files
------------

// File: rtl/intc_pkg.sv
// Shared definitions for the vectored interrupt controller: FSM encoding,
// cause width, default vector layout and the vector address helper.
package intc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        ENTER = 2'd2,
        ISR   = 2'd3
    } intc_state_e;

    localparam int unsigned CAUSE_W       = 4;
    localparam logic [31:0] VEC_BASE_DEF  = 32'h0000_1000;
    localparam int unsigned VEC_SHIFT_DEF = 4;

    // 32-bit vector address, wrapping mod 2^32.
    function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                             input logic [CAUSE_W-1:0] id,
                                             input int unsigned shift);
        return base + (32'(id) << shift);
    endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// Combinational priority encoder: lowest set index wins.
module intc_prio_enc
    import intc_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]       req,
    output logic               valid,
    output logic [CAUSE_W-1:0] id
);

    always_comb begin
        valid = |req;
        id    = '0;
        // Descending scan so the lowest set index is the last assignment.
        for (int unsigned i = N; i > 0; i--) begin
            if (req[i-1]) id = CAUSE_W'(i - 1);
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Vectored interrupt controller driving the next-PC interrupt redirect.
// Define INTC_SYNC_EN to pass irq_i through a 2-flop synchronizer.
module int_ctrl
    import intc_pkg::*;
#(
    parameter int unsigned NUM_IRQ   = 4,
    parameter logic [31:0] VEC_BASE  = VEC_BASE_DEF,
    parameter int unsigned VEC_SHIFT = VEC_SHIFT_DEF
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               cfg_we,
    input  logic [NUM_IRQ:0]   cfg_wdata,
    input  logic [31:0]        npc_i,
    input  logic               stall_i,
    input  logic               mret_i,
    output logic               int_sig_o,
    output logic [31:0]        int_addr_o,
    output logic [NUM_IRQ-1:0] irq_ack_o,
    output logic [31:0]        epc_o,
    output logic [3:0]         cause_o,
    output logic               in_isr_o
);

    intc_state_e        state, state_n;
    logic [NUM_IRQ-1:0] irq_s, irq_q, irq_edge;
    logic [NUM_IRQ-1:0] pend, mask, elig;
    logic               gie, pgie;
    logic [31:0]        epc, int_addr_q;
    logic [CAUSE_W-1:0] cause, win_id;
    logic               win_valid, commit, isr_ret, load_vec;

`ifdef INTC_SYNC_EN
    logic [NUM_IRQ-1:0] sync_ff1, sync_ff2;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_ff1 <= '0;
            sync_ff2 <= '0;
        end else begin
            sync_ff1 <= irq_i;
            sync_ff2 <= sync_ff1;
        end
    end

    always_comb irq_s = sync_ff2;
`else
    always_comb irq_s = irq_i;
`endif

    always_comb begin
        irq_edge = irq_s & ~irq_q;
        elig     = gie ? (pend & mask) : '0;
    end

    intc_prio_enc #(.N(NUM_IRQ)) u_prio_enc (
        .req   (elig),
        .valid (win_valid),
        .id    (win_id)
    );

    always_comb begin
        state_n    = state;
        int_sig_o  = 1'b0;
        int_addr_o = '0;
        commit     = 1'b0;
        isr_ret    = 1'b0;
        load_vec   = 1'b0;
        case (state)
            IDLE: if (win_valid) state_n = ARB;
            ARB: begin
                // A config write landing in IDLE can leave nothing eligible here.
                if (win_valid) begin
                    load_vec = 1'b1;
                    state_n  = ENTER;
                end else begin
                    state_n  = IDLE;
                end
            end
            ENTER: begin
                int_sig_o  = 1'b1;
                int_addr_o = int_addr_q;
                if (!stall_i) begin
                    commit  = 1'b1;
                    state_n = ISR;
                end
            end
            ISR: begin
                if (mret_i) begin
                    int_sig_o  = 1'b1;
                    int_addr_o = epc;
                    isr_ret    = 1'b1;
                    state_n    = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        irq_ack_o = '0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            irq_ack_o[i] = commit && (32'(cause) == i);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            irq_q      <= '0;
            pend       <= '0;
            mask       <= '0;
            gie        <= 1'b0;
            pgie       <= 1'b0;
            epc        <= '0;
            cause      <= '0;
            int_addr_q <= '0;
        end else begin
            state <= state_n;
            irq_q <= irq_s;
            // A new edge on the bit being acknowledged keeps it pending.
            pend  <= (pend & ~irq_ack_o) | irq_edge;
            if (cfg_we) mask <= cfg_wdata[NUM_IRQ-1:0];
            if (commit)       gie <= 1'b0;
            else if (isr_ret) gie <= pgie;
            else if (cfg_we)  gie <= cfg_wdata[NUM_IRQ];
            if (commit) begin
                pgie <= gie;
                epc  <= npc_i;
            end
            if (load_vec) begin
                cause      <= win_id;
                int_addr_q <= vec_addr(VEC_BASE, win_id, VEC_SHIFT);
            end
        end
    end

    always_comb begin
        epc_o    = epc;
        cause_o  = cause;
        in_isr_o = (state == ISR);
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: directed vector tables plus randomized
// stimulus compared against a behavioural reference model.
module tb_int_ctrl;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [N-1:0]  irq_i = '0;
    logic          cfg_we = 1'b0;
    logic [N:0]    cfg_wdata = '0;
    logic [31:0]   npc_i = '0;
    logic          stall_i = 1'b0;
    logic          mret_i = 1'b0;
    logic          int_sig_o;
    logic [31:0]   int_addr_o;
    logic [N-1:0]  irq_ack_o;
    logic [31:0]   epc_o;
    logic [3:0]    cause_o;
    logic          in_isr_o;

    always #5 clk = ~clk;

    int_ctrl #(.NUM_IRQ(N), .VEC_BASE(32'h0000_1000), .VEC_SHIFT(4)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .irq_i      (irq_i),
        .cfg_we     (cfg_we),
        .cfg_wdata  (cfg_wdata),
        .npc_i      (npc_i),
        .stall_i    (stall_i),
        .mret_i     (mret_i),
        .int_sig_o  (int_sig_o),
        .int_addr_o (int_addr_o),
        .irq_ack_o  (irq_ack_o),
        .epc_o      (epc_o),
        .cause_o    (cause_o),
        .in_isr_o   (in_isr_o)
    );

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    typedef struct {
        logic [3:0]  irq;
        logic        we;
        logic [4:0]  wd;
        logic [31:0] npc;
        logic        stall;
        logic        mret;
        logic        sig;
        logic [31:0] addr;
        logic [3:0]  ack;
        logic        isr;
        logic [31:0] epc;
        logic [3:0]  cause;
    } vec_t;

    vec_t tbl_a[$];
    vec_t tbl_b[$];

    function automatic vec_t v(logic [3:0] irq, logic we, logic [4:0] wd, logic [31:0] npc,
                               logic stall, logic mret, logic sig, logic [31:0] addr,
                               logic [3:0] ack, logic isr, logic [31:0] epc, logic [3:0] cause);
        vec_t r;
        r.irq = irq; r.we = we; r.wd = wd; r.npc = npc; r.stall = stall; r.mret = mret;
        r.sig = sig; r.addr = addr; r.ack = ack; r.isr = isr; r.epc = epc; r.cause = cause;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: pending set, config, saved context and which phase of
    // an interrupt entry is in progress.
    logic [3:0]  m_irq_q, m_pend, m_mask;
    logic        m_gie, m_pgie;
    logic [31:0] m_epc, m_vec;
    logic [3:0]  m_cause;
    bit          m_arb, m_enter, m_isr;

    task automatic model_reset();
        m_irq_q = '0; m_pend = '0; m_mask = '0; m_gie = 0; m_pgie = 0;
        m_epc = '0; m_vec = '0; m_cause = '0;
        m_arb = 0; m_enter = 0; m_isr = 0;
    endtask

    task automatic model_check(input string tag);
        logic        e_sig;
        logic [31:0] e_addr;
        logic [3:0]  e_ack;
        e_sig  = m_enter || (m_isr && mret_i);
        e_addr = m_enter ? m_vec : ((m_isr && mret_i) ? m_epc : 32'h0);
        e_ack  = (m_enter && !stall_i) ? (4'b0001 << m_cause) : 4'b0000;
        chk({tag, ".m.sig"},   32'(int_sig_o),  32'(e_sig));
        chk({tag, ".m.addr"},  int_addr_o,      e_addr);
        chk({tag, ".m.ack"},   32'(irq_ack_o),  32'(e_ack));
        chk({tag, ".m.isr"},   32'(in_isr_o),   32'(m_isr));
        chk({tag, ".m.epc"},   epc_o,           m_epc);
        chk({tag, ".m.cause"}, 32'(cause_o),    32'(m_cause));
    endtask

    task automatic model_step();
        logic [3:0] edges, elig;
        int         win;
        bit         commit;
        edges = irq_i & ~m_irq_q;
        elig  = m_gie ? (m_pend & m_mask) : 4'b0000;
        win   = -1;
        for (int i = N - 1; i >= 0; i--) if (elig[i]) win = i;
        commit = m_enter && !stall_i;
        if (commit) m_pend[m_cause] = 1'b0;
        m_pend  = m_pend | edges;
        m_irq_q = irq_i;
        if (commit) begin
            m_epc  = npc_i;
            m_pgie = m_gie;
            m_gie  = 1'b0;
        end else if (m_isr && mret_i) begin
            m_gie = m_pgie;
        end else if (cfg_we) begin
            m_gie = cfg_wdata[N];
        end
        if (cfg_we) m_mask = cfg_wdata[N-1:0];
        if (m_enter) begin
            if (commit) begin m_enter = 0; m_isr = 1; end
        end else if (m_isr) begin
            if (mret_i) m_isr = 0;
        end else if (m_arb) begin
            m_arb = 0;
            if (win >= 0) begin
                m_cause = 4'(win);
                m_vec   = 32'h0000_1000 + 32'(win) * 32'd16;
                m_enter = 1;
            end
        end else if (win >= 0) begin
            m_arb = 1;
        end
    endtask

    task automatic apply(input vec_t t, input bit use_tbl, input string tag);
        irq_i = t.irq; cfg_we = t.we; cfg_wdata = t.wd; npc_i = t.npc;
        stall_i = t.stall; mret_i = t.mret;
        @(negedge clk);
        model_check(tag);
        if (use_tbl) begin
            chk({tag, ".sig"},   32'(int_sig_o), 32'(t.sig));
            chk({tag, ".addr"},  int_addr_o,     t.addr);
            chk({tag, ".ack"},   32'(irq_ack_o), 32'(t.ack));
            chk({tag, ".isr"},   32'(in_isr_o),  32'(t.isr));
            chk({tag, ".epc"},   epc_o,          t.epc);
            chk({tag, ".cause"}, 32'(cause_o),   32'(t.cause));
        end
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".sig"},   32'(int_sig_o), 32'h0);
        chk({tag, ".addr"},  int_addr_o,     32'h0);
        chk({tag, ".ack"},   32'(irq_ack_o), 32'h0);
        chk({tag, ".isr"},   32'(in_isr_o),  32'h0);
        chk({tag, ".epc"},   epc_o,          32'h0);
        chk({tag, ".cause"}, 32'(cause_o),   32'h0);
    endtask

    initial begin
        //            irq     we  wd        npc    st mr  sig addr      ack     isr epc      cause
        // single request, mret return, re-entry of source 2 after gie restore
        tbl_a.push_back(v(4'b0000, 1, 5'b10100, 32'h0,   0, 0, 0, 32'h0,    4'b0000, 0, 32'h0,   4'd0)); // r0
        tbl_a.push_back(v(4'b0100, 0, 5'b0,     32'h0,   0, 0, 0, 32'h0,    4'b0000, 0, 32'h0,   4'd0)); // r1 edge
        tbl_a.push_back(v(4'b0100, 0, 5'b0,     32'h0,   0, 0, 0, 32'h0,    4'b0000, 0, 32'h0,   4'd0));
        tbl_a.push_back(v(4'b0100, 0, 5'b0,     32'h0,   0, 0, 0, 32'h0,    4'b0000, 0, 32'h0,   4'd0));
        tbl_a.push_back(v(4'b0100, 0, 5'b0,     32'h200, 0, 0, 1, 32'h1020, 4'b0100, 0, 32'h0,   4'd2)); // r4 k+3
        tbl_a.push_back(v(4'b0000, 0, 5'b0,     32'h0,   0, 0, 0, 32'h0,    4'b0000, 1, 32'h200, 4'd2));
        tbl_a.push_back(v(4'b0100, 0, 5'b0,     32'h0,   0, 1, 1, 32'h200,  4'b0000, 1, 32'h200, 4'd2)); // r6 mret
        tbl_a.push_back(v(4'b0100, 0, 5'b0,     32'h0,   0, 0, 0, 32'h0,    4'b0000, 0, 32'h200, 4'd2));
        tbl_a.push_back(v(4'b0100, 0, 5'b0,     32'h0,   0, 0, 0, 32'h0,    4'b0000, 0, 32'h200, 4'd2));
        tbl_a.push_back(v(4'b0100, 0, 5'b0,     32'h300, 0, 0, 1, 32'h1020, 4'b0100, 0, 32'h200, 4'd2)); // r9
        tbl_a.push_back(v(4'b0000, 0, 5'b0,     32'h0,   0, 0, 0, 32'h0,    4'b0000, 1, 32'h300, 4'd2));
        tbl_a.push_back(v(4'b0000, 0, 5'b0,     32'h0,   0, 1, 1, 32'h300,  4'b0000, 1, 32'h300, 4'd2));
        tbl_a.push_back(v(4'b0000, 0, 5'b0,     32'h0,   0, 0, 0, 32'h0,    4'b0000, 0, 32'h300, 4'd2)); // r12
        // stall hold in ENTER for 4 cycles
        tbl_a.push_back(v(4'b0001, 1, 5'b11111, 32'h0,   0, 0, 0, 32'h0,    4'b0000, 0, 32'h300, 4'd2));
        tbl_a.push_back(v(4'b0001, 0, 5'b0,     32'h0,   0, 0, 0, 32'h0,    4'b0000, 0, 32'h300, 4'd2));
        tbl_a.push_back(v(4'b0001, 0, 5'b0,     32'h0,   0, 0, 0, 32'h0,    4'b0000, 0, 32'h300, 4'd2));
        for (int i = 0; i < 4; i++)
            tbl_a.push_back(v(4'b0001, 0, 5'b0, 32'h400, 1, 0, 1, 32'h1000, 4'b0000, 0, 32'h300, 4'd0));
        tbl_a.push_back(v(4'b0001, 0, 5'b0,     32'h500, 0, 0, 1, 32'h1000, 4'b0001, 0, 32'h300, 4'd0)); // r20
        tbl_a.push_back(v(4'b0001, 0, 5'b0,     32'h0,   0, 0, 0, 32'h0,    4'b0000, 1, 32'h500, 4'd0));
        tbl_a.push_back(v(4'b0001, 0, 5'b0,     32'h0,   0, 1, 1, 32'h500,  4'b0000, 1, 32'h500, 4'd0));
        tbl_a.push_back(v(4'b0001, 0, 5'b0,     32'h0,   0, 0, 0, 32'h0,    4'b0000, 0, 32'h500, 4'd0)); // r23
        // priority: simultaneous edges on 3 and 1, then back-to-back re-entry
        tbl_a.push_back(v(4'b1011, 0, 5'b0,     32'h0,   0, 0, 0, 32'h0,    4'b0000, 0, 32'h500, 4'd0));
        tbl_a.push_back(v(4'b1011, 0, 5'b0,     32'h0,   0, 0, 0, 32'h0,    4'b0000, 0, 32'h500, 4'd0));
        tbl_a.push_back(v(4'b1011, 0, 5'b0,     32'h0,   0, 0, 0, 32'h0,    4'b0000, 0, 32'h500, 4'd0));
        tbl_a.push_back(v(4'b1011, 0, 5'b0,     32'h600, 0, 0, 1, 32'h1010, 4'b0010, 0, 32'h500, 4'd1)); // r27
        tbl_a.push_back(v(4'b1011, 0, 5'b0,     32'h0,   0, 0, 0, 32'h0,    4'b0000, 1, 32'h600, 4'd1));
        tbl_a.push_back(v(4'b1011, 0, 5'b0,     32'h0,   0, 1, 1, 32'h600,  4'b0000, 1, 32'h600, 4'd1)); // r29 mret
        tbl_a.push_back(v(4'b1011, 0, 5'b0,     32'h0,   0, 0, 0, 32'h0,    4'b0000, 0, 32'h600, 4'd1));
        tbl_a.push_back(v(4'b1011, 0, 5'b0,     32'h0,   0, 0, 0, 32'h0,    4'b0000, 0, 32'h600, 4'd1));
        tbl_a.push_back(v(4'b1011, 0, 5'b0,     32'h700, 0, 0, 1, 32'h1030, 4'b1000, 0, 32'h600, 4'd3)); // r32
        tbl_a.push_back(v(4'b1011, 0, 5'b0,     32'h0,   0, 0, 0, 32'h0,    4'b0000, 1, 32'h700, 4'd3));
        tbl_a.push_back(v(4'b1011, 0, 5'b0,     32'h0,   0, 1, 1, 32'h700,  4'b0000, 1, 32'h700, 4'd3));
        tbl_a.push_back(v(4'b0000, 0, 5'b0,     32'h0,   0, 0, 0, 32'h0,    4'b0000, 0, 32'h700, 4'd3)); // r35
        // masking, mret ignored in IDLE, late unmask
        tbl_a.push_back(v(4'b0000, 1, 5'b11110, 32'h0,   0, 0, 0, 32'h0,    4'b0000, 0, 32'h700, 4'd3));
        for (int i = 0; i < 4; i++)
            tbl_a.push_back(v(4'b0001, 0, 5'b0, 32'h0,   0, 0, 0, 32'h0,    4'b0000, 0, 32'h700, 4'd3));
        tbl_a.push_back(v(4'b0001, 0, 5'b0,     32'h0,   0, 1, 0, 32'h0,    4'b0000, 0, 32'h700, 4'd3)); // r41
        tbl_a.push_back(v(4'b0001, 1, 5'b10001, 32'h0,   0, 0, 0, 32'h0,    4'b0000, 0, 32'h700, 4'd3));
        tbl_a.push_back(v(4'b0001, 0, 5'b0,     32'h0,   0, 0, 0, 32'h0,    4'b0000, 0, 32'h700, 4'd3));
        tbl_a.push_back(v(4'b0001, 0, 5'b0,     32'h0,   0, 0, 0, 32'h0,    4'b0000, 0, 32'h700, 4'd3));
        tbl_a.push_back(v(4'b0001, 0, 5'b0,     32'h800, 0, 0, 1, 32'h1000, 4'b0001, 0, 32'h700, 4'd0)); // r45
        tbl_a.push_back(v(4'b0001, 0, 5'b0,     32'h0,   0, 0, 0, 32'h0,    4'b0000, 1, 32'h800, 4'd0)); // r46 ISR

        // after reset mid-ISR: nothing pending, new edge serviced normally
        tbl_b.push_back(v(4'b0000, 1, 5'b11111, 32'h0,   0, 0, 0, 32'h0,    4'b0000, 0, 32'h0,   4'd0));
        tbl_b.push_back(v(4'b0000, 0, 5'b0,     32'h0,   0, 0, 0, 32'h0,    4'b0000, 0, 32'h0,   4'd0));
        tbl_b.push_back(v(4'b0000, 0, 5'b0,     32'h0,   0, 0, 0, 32'h0,    4'b0000, 0, 32'h0,   4'd0));
        tbl_b.push_back(v(4'b0100, 0, 5'b0,     32'h0,   0, 0, 0, 32'h0,    4'b0000, 0, 32'h0,   4'd0));
        tbl_b.push_back(v(4'b0100, 0, 5'b0,     32'h0,   0, 0, 0, 32'h0,    4'b0000, 0, 32'h0,   4'd0));
        tbl_b.push_back(v(4'b0100, 0, 5'b0,     32'h0,   0, 0, 0, 32'h0,    4'b0000, 0, 32'h0,   4'd0));
        tbl_b.push_back(v(4'b0100, 0, 5'b0,     32'h900, 0, 0, 1, 32'h1020, 4'b0100, 0, 32'h0,   4'd2));
        tbl_b.push_back(v(4'b0100, 0, 5'b0,     32'h0,   0, 0, 0, 32'h0,    4'b0000, 1, 32'h900, 4'd2));
        tbl_b.push_back(v(4'b0100, 0, 5'b0,     32'h0,   0, 1, 1, 32'h900,  4'b0000, 1, 32'h900, 4'd2));
        tbl_b.push_back(v(4'b0100, 0, 5'b0,     32'h0,   0, 0, 0, 32'h0,    4'b0000, 0, 32'h900, 4'd2));

        // Power-on reset.
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rstn = 1'b1;

        foreach (tbl_a[i]) apply(tbl_a[i], 1'b1, $sformatf("a%0d", i));

        // Asynchronous reset while in ISR.
        #2;
        rstn = 1'b0;
        irq_i = '0; cfg_we = 0; cfg_wdata = '0; stall_i = 0; mret_i = 0; npc_i = '0;
        #1;
        chk_all_zero("rst_isr");
        model_reset();
        @(posedge clk);
        #1;
        rstn = 1'b1;

        foreach (tbl_b[i]) apply(tbl_b[i], 1'b1, $sformatf("b%0d", i));

        // Randomized traffic against the reference model.
        begin
            logic [3:0] irq_r;
            vec_t       t;
            irq_r = irq_i;
            for (int c = 0; c < 3000; c++) begin
                for (int b = 0; b < N; b++)
                    if ($urandom_range(7) == 0) irq_r[b] = ~irq_r[b];
                t = v(irq_r, ($urandom_range(15) == 0), 5'b0, $urandom(),
                      ($urandom_range(2) == 0), ($urandom_range(3) == 0),
                      0, 32'h0, 4'b0, 0, 32'h0, 4'd0);
                t.wd = {($urandom_range(7) != 0), 4'($urandom_range(15))};
                apply(t, 1'b0, $sformatf("rnd%0d", c));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
